n3_gtp_encap: RTL

Downlink GTP-U encapsulator: takes a per-packet descriptor and an inner IPv4 packet byte stream from the N6 side, and emits a complete N3 frame. The frame is built as Ethernet + outer IPv4 + UDP + GTP-U (+ optional PDU session container) headers, followed by the unmodified inner packet. It is the transmit-side counterpart of the N3 parser and sits between the forwarding stage and the N3 MAC.

---
 rtl/n3_gtp_encap.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/n3_gtp_encap.sv
// n3_gtp_encap: downlink GTP-U encapsulator (Eth+IPv4+UDP+GTP-U header, then inner packet); N3_GTP_PDU_EXT_EN adds the PDU session container
module n3_gtp_encap (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [47:0] desc_dst_mac,
  input  logic [47:0] desc_src_mac,
  input  logic [31:0] desc_src_ip,
  input  logic [31:0] desc_dst_ip,
  input  logic [31:0] desc_teid,
  input  logic [5:0]  desc_qfi,
  input  logic [5:0]  desc_dscp,
  input  logic [15:0] desc_inner_len,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err_len,
  output logic        err_oversize,
  output logic [31:0] pkt_count
);
`ifdef N3_GTP_PDU_EXT_EN
  localparam int G = 16;
`else
  localparam int G = 8;
`endif
  localparam int H = 42 + G;
  localparam logic [5:0] H_LAST = 6'(H - 1);
  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, DROP} state_t;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [31:0] teid;
    logic [5:0]  qfi;
    logic [5:0]  dscp;
    logic [15:0] len;
  } desc_t;
  state_t        state_q, state_d;
  desc_t         desc_q, desc_d;
  logic [5:0]    idx_q, idx_d;
  logic [19:0]   sum_q, sum_d;
  logic [15:0]   cnt_q, cnt_d, ip_id_q, ip_id_d;
  logic [31:0]   pkt_q, pkt_d;
  logic          err_len_q, err_len_d, err_ovs_q, err_ovs_d;
  logic [16:0]   tl_new, fold1;
  logic [15:0]   tl, csum, ip_word, glen;
  logic [159:0]  ip0;
  logic [8*G-1:0] gtp;
  logic [8*H-1:0] hdr;
  logic [7:0]    hdr_byte;
  logic          unused;
  assign tl_new   = 17'(28 + G) + {1'b0, desc_inner_len};
  assign tl       = 16'(28 + G) + desc_q.len;
  assign glen     = desc_q.len + 16'(G - 8);
  assign ip0      = {8'h45, desc_q.dscp, 2'b00, tl, ip_id_q, 16'h4000, 8'd64, 8'd17, 16'h0000, desc_q.src_ip, desc_q.dst_ip};
  assign ip_word  = 16'(ip0 >> {4'd9 - idx_q[3:0], 4'b0000});
  assign fold1    = {1'b0, sum_q[15:0]} + {13'b0, sum_q[19:16]};
  assign csum     = ~(fold1[15:0] + {15'b0, fold1[16]});
`ifdef N3_GTP_PDU_EXT_EN
  assign gtp = {8'h34, 8'hFF, glen, desc_q.teid, 16'h0000, 8'h00, 8'h85, 8'h01, 8'h00, 2'b00, desc_q.qfi, 8'h00};
`else
  assign gtp = {8'h30, 8'hFF, glen, desc_q.teid};
`endif
  assign hdr      = {desc_q.dst_mac, desc_q.src_mac, 16'h0800, ip0[159:80], csum, ip0[63:0],
                     16'd2152, 16'd2152, 16'(8 + G) + desc_q.len, 16'h0000, gtp};
  assign hdr_byte = 8'(hdr >> {H_LAST - idx_q, 3'b000});
  assign unused   = ^{ip0[79:64], desc_q.qfi};
  assign desc_ready   = state_q == IDLE;
  assign in_ready     = state_q == PAYLOAD ? out_ready : state_q == DROP;
  assign out_valid    = state_q == HDR || (state_q == PAYLOAD && in_valid);
  assign out_data     = state_q == HDR ? hdr_byte : state_q == PAYLOAD ? in_data : 8'h00;
  assign out_last     = state_q == PAYLOAD && in_last;
  assign err_len      = err_len_q;
  assign err_oversize = err_ovs_q;
  assign pkt_count    = pkt_q;
  always_comb begin
    state_d   = state_q;
    desc_d    = desc_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    pkt_d     = pkt_q;
    ip_id_d   = ip_id_q;
    err_len_d = 1'b0;
    err_ovs_d = 1'b0;
    case (state_q)
      IDLE: if (desc_valid) begin
        desc_d    = {desc_dst_mac, desc_src_mac, desc_src_ip, desc_dst_ip, desc_teid, desc_qfi, desc_dscp, desc_inner_len};
        idx_d     = '0;
        sum_d     = '0;
        err_ovs_d = tl_new[16];
        state_d   = tl_new[16] ? DROP : CSUM;
      end
      CSUM: begin
        sum_d   = sum_q + {4'b0, ip_word};
        idx_d   = idx_q == 6'd9 ? 6'd0 : idx_q + 6'd1;
        state_d = idx_q == 6'd9 ? HDR : CSUM;
      end
      HDR: if (out_ready) begin
        idx_d   = idx_q + 6'd1;
        cnt_d   = '0;
        state_d = idx_q == H_LAST ? PAYLOAD : HDR;
      end
      PAYLOAD: if (in_valid && out_ready) begin
        cnt_d = cnt_q + 16'd1;
        if (in_last) begin
          err_len_d = cnt_d != desc_q.len;
          pkt_d     = pkt_q + 32'd1;
          ip_id_d   = ip_id_q + 16'd1;
          state_d   = IDLE;
        end
      end
      DROP: if (in_valid && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      desc_q    <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      pkt_q     <= '0;
      ip_id_q   <= '0;
      err_len_q <= 1'b0;
      err_ovs_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      desc_q    <= desc_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      pkt_q     <= pkt_d;
      ip_id_q   <= ip_id_d;
      err_len_q <= err_len_d;
      err_ovs_q <= err_ovs_d;
    end
  end
endmodule
